uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between N_REQ client blocks. Round-robin
//  arbitration per message; a grant is held across a multi-byte message, up to
//  MAX_BURST bytes. Drives the UART transmit strobe and tx_byte, and tracks
//  is_transmitting to sequence bytes back-to-back. Sits between client logic
//  and the UART core in the top level.
// PARAMETERS
//  N_REQ          4      number of requesters (2..8)
//  MAX_BURST      16     max bytes per grant before forced release (>=1)
//  START_TIMEOUT  1024   cycles to wait for is_transmitting after strobe
// PORTS
//  clk               in   1        system clock, rising edge
//  rst_n             in   1        asynchronous reset, active-low
//  req               in   N_REQ    per-client request; hold high until ack
//  req_byte          in   8*N_REQ  client i byte = req_byte[8*i+7:8*i]
//  req_last          in   N_REQ    client byte is last of its message
//  ack               out  N_REQ    1-cycle pulse: client byte accepted by UART
//  grant             out  N_REQ    one-hot current owner, 0 when idle
//  uart_transmit     out  1        transmit strobe to UART
//  uart_tx_byte      out  8        byte to UART, stable while strobe/busy
//  uart_is_transmitting in 1       UART busy flag
//  timeout_err       out  1        1-cycle pulse: UART did not start in time
//  busy              out  1        1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, state IDLE, rr pointer=0, counters 0.
//   Takes effect immediately mid-operation; uart_transmit drops same instant.
//  States: IDLE, LAUNCH, WAIT_DONE.
//  IDLE: if |req and !uart_is_transmitting: pick first i with req[i]=1 searching
//   ptr, ptr+1, ... mod N_REQ. Next edge: grant=onehot(i), uart_tx_byte and
//   last_q latched from client i, burst_cnt=1, tmo_cnt=0, -> LAUNCH. req
//   high at cycle t gives grant at t+1 (1-cycle latency). Else stay.
//  LAUNCH: uart_transmit=1. tmo_cnt increments each cycle.
//   - uart_is_transmitting=1: next edge transmit=0, ack[i]=1 for one cycle,
//     -> WAIT_DONE.
//   - tmo_cnt reaches START_TIMEOUT-1 first: transmit=0, timeout_err pulse,
//     no ack, grant=0, ptr=(i+1) mod N_REQ, -> IDLE. Client i keeps its req.
//  WAIT_DONE: wait for uart_is_transmitting=0. On that cycle:
//   - continue if last_q=0 and req[i]=1 and burst_cnt<MAX_BURST: latch next
//     req_byte/req_last of i, burst_cnt+1, tmo_cnt=0, grant kept, -> LAUNCH.
//   - otherwise release: grant=0, ptr=(i+1) mod N_REQ, -> IDLE.
//  Client rules: req_byte/req_last sampled only on grant or continue edge;
//   client may change them after its ack. Dropping req after ack ends message.
//   Dropping req before ack is ignored: latched byte still sent, ack issued.
//  Simultaneous requests: lower offset from ptr wins; losers wait, no ack.
//  Forced release at MAX_BURST: ptr advances, client re-arbitrates normally.
//  ack, timeout_err never both high. grant always one-hot or 0. burst_cnt width
//   $clog2(MAX_BURST+1); tmo_cnt width $clog2(START_TIMEOUT+1), saturates.
//  Byte-to-strobe gap: 1 cycle after busy falls (continue) or 2 (re-arbitrate).
// TESTING
//  1 Reset then req=4'b0001, byte 0x41, last=1; UART model busy 3 cycles after
//    strobe -> grant 0001 at t+1, transmit until busy, one ack[0], 0x41 sent.
//  2 req=4'b1111 all last=1, held after ack -> service order 0,1,2,3,0 with
//    one ack each; ptr wraps 3->0.
//  3 Client 2 sends 0x10,0x11,0x12 (last on 0x12) with client 0 also requesting
//    -> three bytes contiguous, grant stays 0100, then client 0 granted.
//  4 MAX_BURST=2, client 1 never asserts last, client 3 requesting -> after 2
//    acks grant goes to client 3, then back to 1.
//  5 UART model never asserts busy -> timeout_err pulse after START_TIMEOUT
//    cycles, no ack, grant=0, transmit=0, IDLE.
//  6 rst_n low during WAIT_DONE -> all outputs 0 immediately; after release
//    first grant goes to lowest requesting index.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N_REQ clients.
// Round-robin arbitration per message; the grant is held across a multi-byte
// message for up to MAX_BURST bytes, then force-released.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req/req_byte/req_last per-client request, byte and end-of-message flag
//   ack                   1-cycle pulse when the client byte is taken by the UART
//   grant                 one-hot current owner, 0 when idle
//   uart_transmit         transmit strobe, held until the UART reports busy
//   uart_tx_byte          byte presented to the UART
//   uart_is_transmitting  UART busy flag
//   timeout_err           1-cycle pulse when the UART never started
//   busy                  arbiter not idle
module uart_tx_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned MAX_BURST     = 16,
  parameter int unsigned START_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_byte,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     grant,
  output logic                 uart_transmit,
  output logic [7:0]           uart_tx_byte,
  input  logic                 uart_is_transmitting,
  output logic                 timeout_err,
  output logic                 busy
);

  localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
  localparam int unsigned TMO_W   = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     idx_q, idx_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic [7:0]           byte_q, byte_d;
  logic                 last_q, last_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic                 tmo_err_q, tmo_err_d;
  logic                 xmit_q, xmit_d;
  logic                 busy_q, busy_d;

  logic                 found;
  logic [PTR_W-1:0]     win_idx;

  function automatic logic [PTR_W-1:0] wrap_idx(input int unsigned v);
    return PTR_W'(v % N_REQ);
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] i);
    return (i == PTR_W'(N_REQ - 1)) ? '0 : i + PTR_W'(1);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
    logic [N_REQ-1:0] o;
    o    = '0;
    o[i] = 1'b1;
    return o;
  endfunction

  function automatic logic [7:0] byte_of(input logic [8*N_REQ-1:0] bytes,
                                         input logic [PTR_W-1:0]   i);
    logic [7:0] b;
    b = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (PTR_W'(k) == i) b = bytes[8*k +: 8];
    end
    return b;
  endfunction

  // Round-robin search starting at ptr: first requester at the lowest offset wins
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && req[wrap_idx(32'(ptr_q) + k)]) begin
        found   = 1'b1;
        win_idx = wrap_idx(32'(ptr_q) + k);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    byte_d    = byte_q;
    last_d    = last_q;
    burst_d   = burst_q;
    tmo_d     = tmo_q;
    ack_d     = '0;
    tmo_err_d = 1'b0;
    xmit_d    = xmit_q;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        if (found && !uart_is_transmitting) begin
          grant_d = onehot(win_idx);
          idx_d   = win_idx;
          byte_d  = byte_of(req_byte, win_idx);
          last_d  = req_last[win_idx];
          burst_d = BURST_W'(1);
          tmo_d   = '0;
          xmit_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (uart_is_transmitting) begin
          xmit_d  = 1'b0;
          ack_d   = grant_q;
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_W'(START_TIMEOUT - 1)) begin
          // UART never started: give up this owner, it re-arbitrates later
          xmit_d    = 1'b0;
          tmo_err_d = 1'b1;
          grant_d   = '0;
          ptr_d     = next_ptr(idx_q);
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (tmo_q != TMO_W'(START_TIMEOUT)) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!uart_is_transmitting) begin
          if (!last_q && req[idx_q] && (burst_q < BURST_W'(MAX_BURST))) begin
            byte_d  = byte_of(req_byte, idx_q);
            last_d  = req_last[idx_q];
            burst_d = burst_q + BURST_W'(1);
            tmo_d   = '0;
            xmit_d  = 1'b1;
            state_d = LAUNCH;
          end else begin
            grant_d = '0;
            ptr_d   = next_ptr(idx_q);
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        xmit_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      grant_q   <= '0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      burst_q   <= '0;
      tmo_q     <= '0;
      ack_q     <= '0;
      tmo_err_q <= 1'b0;
      xmit_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      tmo_q     <= tmo_d;
      ack_q     <= ack_d;
      tmo_err_q <= tmo_err_d;
      xmit_q    <= xmit_d;
      busy_q    <= busy_d;
    end
  end

  assign ack           = ack_q;
  assign grant         = grant_q;
  assign uart_transmit = xmit_q;
  assign uart_tx_byte  = byte_q;
  assign timeout_err   = tmo_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-client byte queues drive the requests, a
// message-level round-robin scheduler predicts the order of bytes reaching the
// UART, and a reactive UART model supplies randomized start delay / busy time.
module tb_uart_tx_arbiter;

  localparam int unsigned TB_N     = 4;
  localparam int unsigned TB_BURST = 3;
  localparam int unsigned TB_TMO   = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [TB_N-1:0]   req;
  logic [8*TB_N-1:0] req_byte;
  logic [TB_N-1:0]   req_last;
  logic [TB_N-1:0]   ack;
  logic [TB_N-1:0]   grant;
  logic              uart_transmit;
  logic [7:0]        uart_tx_byte;
  logic              uart_is_transmitting;
  logic              timeout_err;
  logic              busy;

  uart_tx_arbiter #(
    .N_REQ(TB_N), .MAX_BURST(TB_BURST), .START_TIMEOUT(TB_TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_byte(req_byte),
    .req_last(req_last), .ack(ack), .grant(grant),
    .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // client queues
  logic [7:0] byte_mem [TB_N][64];
  bit         last_mem [TB_N][64];
  int         head [TB_N];
  int         tail [TB_N];
  int         ack_cnt [TB_N];
  int         exp_ack [TB_N];
  logic [9:0] exp_q [$];
  int         model_ptr;

  // UART model
  bit uart_dead;
  int u_phase;
  int u_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic start_scenario();
    for (int c = 0; c < TB_N; c++) begin
      head[c] = 0; tail[c] = 0; ack_cnt[c] = 0; exp_ack[c] = 0;
    end
    exp_q.delete();
  endtask

  task automatic add_byte(input int c, input logic [7:0] b, input bit l);
    byte_mem[c][tail[c]] = b;
    last_mem[c][tail[c]] = l;
    tail[c]++;
  endtask

  task automatic add_msg(input int c, input int len, input bit with_last);
    for (int j = 0; j < len; j++) add_byte(c, 8'($urandom), with_last && (j == len - 1));
  endtask

  // Message-level scheduler: owner keeps sending until last, empty queue or burst cap
  task automatic build_expected();
    int  h [TB_N];
    int  c;
    int  cand;
    int  cnt;
    bit  more;
    bit  found;
    bit  lst;
    for (int i = 0; i < TB_N; i++) h[i] = head[i];
    more = 1'b1;
    while (more) begin
      found = 1'b0;
      c = 0;
      for (int k = 0; k < TB_N; k++) begin
        cand = (model_ptr + k) % TB_N;
        if (!found && h[cand] < tail[cand]) begin
          found = 1'b1;
          c = cand;
        end
      end
      if (!found) begin
        more = 1'b0;
      end else begin
        cnt = 0;
        do begin
          exp_q.push_back({c[1:0], byte_mem[c][h[c]]});
          lst = last_mem[c][h[c]];
          h[c]++;
          cnt++;
          exp_ack[c]++;
        end while (!lst && cnt < TB_BURST && h[c] < tail[c]);
        model_ptr = (c + 1) % TB_N;
      end
    end
  endtask

  task automatic drive();
    for (int c = 0; c < TB_N; c++) begin
      if (head[c] < tail[c]) begin
        req[c]            = 1'b1;
        req_byte[8*c +: 8] = byte_mem[c][head[c]];
        req_last[c]       = last_mem[c][head[c]];
      end else begin
        req[c]            = 1'b0;
        req_byte[8*c +: 8] = 8'($urandom);
        req_last[c]       = 1'($urandom);
      end
    end
  endtask

  task automatic uart_model();
    logic [9:0] e;
    case (u_phase)
      0: begin
        if (uart_transmit && !uart_dead) begin
          if (exp_q.size() == 0) begin
            check("sb_extra_byte", 32'(uart_tx_byte), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("sb_byte", 32'(uart_tx_byte), 32'(e[7:0]));
            check("sb_grant", 32'(grant), 32'(4'b0001 << e[9:8]));
          end
          u_cnt = int'($urandom_range(0, 3));
          if (u_cnt == 0) begin
            uart_is_transmitting = 1'b1;
            u_cnt = int'($urandom_range(1, 4));
            u_phase = 2;
          end else begin
            u_phase = 1;
          end
        end
      end
      1: begin
        u_cnt--;
        if (u_cnt == 0) begin
          uart_is_transmitting = 1'b1;
          u_cnt = int'($urandom_range(1, 4));
          u_phase = 2;
        end
      end
      default: begin
        u_cnt--;
        if (u_cnt == 0) begin
          uart_is_transmitting = 1'b0;
          u_phase = 0;
        end
      end
    endcase
  endtask

  // One cycle: sample on the falling edge, then react and drive for the next rising edge
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      check("ack_in_grant", 32'(ack & ~grant), 32'd0);
      check("ack_tmo_excl", 32'((|ack) & timeout_err), 32'd0);
      if (!uart_dead) check("no_timeout", 32'(timeout_err), 32'd0);
      for (int c = 0; c < TB_N; c++) begin
        if (ack[c]) begin
          check("ack_has_data", 32'(head[c] < tail[c]), 32'd1);
          if (head[c] < tail[c]) head[c]++;
          ack_cnt[c]++;
        end
      end
    end
    uart_model();
    drive();
  endtask

  function automatic bit queues_empty();
    bit e;
    e = 1'b1;
    for (int c = 0; c < TB_N; c++) if (head[c] < tail[c]) e = 1'b0;
    return e;
  endfunction

  task automatic run_until_done(input string tag);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      tick();
      n++;
      done = (exp_q.size() == 0) && queues_empty() && !busy && (u_phase == 0);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idle_grant"}, 32'(grant), 32'd0);
    for (int c = 0; c < TB_N; c++) check({tag, "_ack_cnt"}, 32'(ack_cnt[c]), 32'(exp_ack[c]));
  endtask

  initial begin
    int  n;
    bit  seen;
    rst_n = 1'b0;
    req = '0; req_byte = '0; req_last = '0;
    uart_is_transmitting = 1'b0;
    uart_dead = 1'b0; u_phase = 0; u_cnt = 0; model_ptr = 0;
    start_scenario();
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({ack, grant, uart_transmit, uart_tx_byte, timeout_err, busy}), 32'd0);
    rst_n = 1'b1;

    // single byte: one-cycle grant latency, byte 0x41 delivered
    start_scenario();
    add_byte(0, 8'h41, 1'b1);
    build_expected();
    tick();
    @(posedge clk); #1;
    check("t1_grant_latency", 32'(grant), 32'b0001);
    check("t1_strobe", 32'(uart_transmit), 32'd1);
    run_until_done("t1");

    // all clients requesting, client 0 with a second message
    start_scenario();
    for (int c = 0; c < TB_N; c++) add_msg(c, 1, 1'b1);
    add_msg(0, 1, 1'b1);
    build_expected();
    run_until_done("t2");

    // three-byte message held contiguously while client 0 waits
    start_scenario();
    add_byte(2, 8'h10, 1'b0);
    add_byte(2, 8'h11, 1'b0);
    add_byte(2, 8'h12, 1'b1);
    add_byte(0, 8'h55, 1'b1);
    build_expected();
    run_until_done("t3");

    // message without last: forced release at the burst cap
    start_scenario();
    add_msg(1, 5, 1'b0);
    add_msg(3, 1, 1'b1);
    build_expected();
    run_until_done("t4");

    // UART never starts: timeout after START_TIMEOUT cycles
    start_scenario();
    uart_dead = 1'b1;
    add_byte(1, 8'hA5, 1'b1);
    n = 0; seen = 1'b0;
    while (!seen && n < 50) begin tick(); n++; seen = uart_transmit; end
    check("tmo_strobe_seen", 32'(seen), 32'd1);
    n = 0; seen = 1'b0;
    while (!seen && n < int'(TB_TMO) + 20) begin tick(); n++; seen = timeout_err; end
    check("tmo_seen", 32'(seen), 32'd1);
    check("tmo_cycles", 32'(n), 32'(TB_TMO));
    head[1] = tail[1];
    drive();
    #1;
    check("tmo_no_ack", 32'(ack), 32'd0);
    check("tmo_grant", 32'(grant), 32'd0);
    check("tmo_strobe_low", 32'(uart_transmit), 32'd0);
    check("tmo_idle", 32'(busy), 32'd0);
    tick();
    check("tmo_pulse_width", 32'(timeout_err), 32'd0);
    check("tmo_grant_stays", 32'(grant), 32'd0);
    uart_dead = 1'b0;
    model_ptr = 2;

    // randomized message mixes
    for (int r = 0; r < 25; r++) begin
      start_scenario();
      for (int c = 0; c < TB_N; c++) begin
        if ($urandom_range(0, 1) == 1 || (c == TB_N - 1 && queues_empty())) begin
          add_msg(c, int'($urandom_range(1, 5)), $urandom_range(0, 3) != 0);
          if ($urandom_range(0, 1) == 1) add_msg(c, int'($urandom_range(1, 4)), 1'b1);
        end
      end
      build_expected();
      run_until_done("rnd");
    end

    // reset during WAIT_DONE, with the pointer sitting at 2
    start_scenario();
    add_msg(1, 1, 1'b1);
    build_expected();
    run_until_done("rst_pre");
    start_scenario();
    add_msg(3, 1, 1'b1);
    build_expected();
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin tick(); n++; seen = ack[3]; end
    check("rst_ack_seen", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({ack, grant, uart_transmit, uart_tx_byte, timeout_err, busy}), 32'd0);
    start_scenario();
    uart_is_transmitting = 1'b0;
    u_phase = 0;
    model_ptr = 0;
    drive();
    #2;
    rst_n = 1'b1;
    add_msg(1, 1, 1'b1);
    add_msg(3, 1, 1'b1);
    build_expected();
    tick();
    @(posedge clk); #1;
    check("rst_first_grant", 32'(grant), 32'b0010);
    run_until_done("rst_post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
